alu_seq: RTL and testbench

//  Parametrised multi-cycle integer execute unit for the RISC-V core; successor to the single-cycle ALU.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_iter_core.sv | 83 ++++++++
 rtl/alu_seq.sv | 164 ++++++++++++++++
 tb/tb_alu_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential execute unit.
// Opcodes, FSM state encoding and opcode class helpers.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h1;
  localparam logic [3:0] ALU_AND   = 4'h2;
  localparam logic [3:0] ALU_OR    = 4'h3;
  localparam logic [3:0] ALU_XOR   = 4'h4;
  localparam logic [3:0] ALU_SLL   = 4'h5;
  localparam logic [3:0] ALU_SRL   = 4'h6;
  localparam logic [3:0] ALU_SRA   = 4'h7;
  localparam logic [3:0] ALU_SLT   = 4'h8;
  localparam logic [3:0] ALU_SLTU  = 4'h9;
  localparam logic [3:0] ALU_MUL   = 4'hA;
  localparam logic [3:0] ALU_MULHU = 4'hB;
  localparam logic [3:0] ALU_DIVU  = 4'hC;
  localparam logic [3:0] ALU_REMU  = 4'hD;
  localparam logic [3:0] ALU_DIV   = 4'hE;
  localparam logic [3:0] ALU_REM   = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A..F use the multi-cycle datapath
  function automatic logic is_iter(input logic [3:0] op);
    return op[3] & (op[2] | op[1]);
  endfunction

  // C..F
  function automatic logic is_div(input logic [3:0] op);
    return op[3] & op[2];
  endfunction

  // E, F
  function automatic logic is_sdiv(input logic [3:0] op);
    return op[3] & op[2] & op[1];
  endfunction

endpackage

// File: rtl/alu_iter_core.sv
// Iterative unsigned shift-add multiplier / restoring divider.
// Ports: clk, rst, clear, start, div_mode, a, b -> done, lo, hi (next-step values).
module alu_iter_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             start,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int SHW = $clog2(WIDTH);

  logic             run;
  logic             mode;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rs;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] hi_n;
  logic [WIDTH-1:0] lo_n;

  // mul: {hi,lo} = partial product, lo holds unused multiplier bits
  // div: hi = partial remainder, lo shifts dividend out / quotient in
  always_comb begin
    sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    rs   = {acc_hi, acc_lo[WIDTH-1]};
    diff = rs - {1'b0, opnd};
    if (mode) begin
      hi_n = diff[WIDTH] ? rs[WIDTH-1:0] : diff[WIDTH-1:0];
      lo_n = {acc_lo[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // Final step is exposed combinationally so the owner can
  // capture the result on the same edge the count expires.
  assign done = run & (cnt == '0);
  assign lo   = lo_n;
  assign hi   = hi_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run    <= 1'b0;
      mode   <= 1'b0;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
    end else if (clear) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run    <= 1'b1;
      mode   <= div_mode;
      cnt    <= SHW'(WIDTH - 1);
      acc_hi <= '0;
      acc_lo <= div_mode ? a : b;
      opnd   <= div_mode ? b : a;
    end else if (run) begin
      acc_hi <= hi_n;
      acc_lo <= lo_n;
      cnt    <= cnt - 1'b1;
      if (cnt == '0)
        run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle integer execute unit with valid/ready on both sides.
// Ports: clk, rst, flush, in_valid/in_ready, a, b, alu_ctrl, out_valid/out_ready, result, zero, busy.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state_q, state_d;

  logic             accept;
  logic             b_zero;
  logic             ovf;
  logic             special;
  logic             iter_go;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] fast;

  logic             hi_sel_q;
  logic             q_neg_q;
  logic             r_neg_q;

  logic             core_done;
  logic [WIDTH-1:0] core_lo;
  logic [WIDTH-1:0] core_hi;
  logic [WIDTH-1:0] iter_res;

  logic             res_en;
  logic [WIDTH-1:0] res_d;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);

  assign accept  = in_valid & in_ready & ~flush;
  assign b_zero  = (b == '0);
  assign ovf     = (a == MIN) & (b == '1);
  // div by zero and signed overflow finish in one cycle
  assign special = is_div(alu_ctrl) & (b_zero | (is_sdiv(alu_ctrl) & ovf));
  assign iter_go = is_iter(alu_ctrl) & ~special;

  assign a_neg = is_sdiv(alu_ctrl) & a[WIDTH-1];
  assign b_neg = is_sdiv(alu_ctrl) & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign shamt = b[SHW-1:0];

  always_comb begin
    fast = '0;
    unique case (alu_ctrl)
      ALU_ADD:   fast = a + b;
      ALU_SUB:   fast = a - b;
      ALU_AND:   fast = a & b;
      ALU_OR:    fast = a | b;
      ALU_XOR:   fast = a ^ b;
      ALU_SLL:   fast = a << shamt;
      ALU_SRL:   fast = a >> shamt;
      ALU_SRA:   fast = $unsigned($signed(a) >>> shamt);
      ALU_SLT:   fast = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:  fast = {{(WIDTH-1){1'b0}}, a < b};
      // multiplies never take this path
      ALU_MUL:   fast = '0;
      ALU_MULHU: fast = '0;
      ALU_DIVU:  fast = '1;
      ALU_REMU:  fast = a;
      ALU_DIV:   fast = b_zero ? '1 : MIN;
      ALU_REM:   fast = b_zero ? a : '0;
    endcase
  end

  alu_iter_core #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .start    (accept & iter_go),
    .div_mode (alu_ctrl[2]),
    .a        (a_mag),
    .b        (b_mag),
    .done     (core_done),
    .lo       (core_lo),
    .hi       (core_hi)
  );

  // hi half carries MULHU / remainder, lo half MUL / quotient
  assign iter_res = hi_sel_q ? (r_neg_q ? -core_hi : core_hi)
                             : (q_neg_q ? -core_lo : core_lo);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = iter_go ? ST_BUSY : ST_DONE;
      ST_BUSY: if (core_done) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush)
      state_d = ST_IDLE;
  end

  always_comb begin
    res_en = 1'b0;
    res_d  = result;
    if (!flush) begin
      if (accept && !iter_go) begin
        res_en = 1'b1;
        res_d  = fast;
      end else if (state_q == ST_BUSY && core_done) begin
        res_en = 1'b1;
        res_d  = iter_res;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result   <= '0;
      zero     <= 1'b0;
      hi_sel_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else begin
      if (accept) begin
        hi_sel_q <= alu_ctrl[0];
        q_neg_q  <= a_neg ^ b_neg;
        r_neg_q  <= a_neg;
      end
      if (res_en) begin
        result <= res_d;
        zero   <= (res_d == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed ops, latency,
// backpressure, flush and mid-op reset.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   alu_ctrl;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alu_ctrl  (alu_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // monitor: one pop per completed handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %h want none", result);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result", result, mon_e);
        chk("zero", W'(zero), W'(mon_e == '0));
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    int n;
    @(negedge clk);
    alu_ctrl = op;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("in_ready_timeout", W'(in_ready), W'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic run_op(input string name, input logic [3:0] op,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] exp, input int lat_exp,
                        input int hold);
    int lat;
    logic rdy_bad;
    out_ready = (hold == 0);
    issue(op, x, y);
    exp_q.push_back(exp);
    lat = 1;
    rdy_bad = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_bad = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_latency"}, W'(lat), W'(lat_exp));
    if (lat_exp > 1) chk({name, "_in_ready_busy"}, W'(rdy_bad), W'(0));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({name, "_hold_result"}, result, exp);
      chk({name, "_hold_valid"}, W'(out_valid), W'(1));
      chk({name, "_hold_in_ready"}, W'(in_ready), W'(0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({name, "_valid_drop"}, W'(out_valid), W'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    alu_ctrl = ALU_ADD;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, '0);
    chk("rst_zero", W'(zero), W'(0));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_busy", W'(busy), W'(0));
    @(negedge clk);
    rst = 1'b0;

    run_op("add", ALU_ADD, 32'd7, 32'd5, 32'd12, 1, 0);
    run_op("sub", ALU_SUB, 32'd5, 32'd5, 32'd0, 1, 0);
    run_op("sra", ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1, 0);
    run_op("srl", ALU_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 1, 0);
    run_op("sll", ALU_SLL, 32'h0000_00F1, 32'h0000_0024, 32'h0000_0F10, 1, 0);
    run_op("xor", ALU_XOR, 32'hF0F0_1234, 32'h0FF0_0034, 32'hFF00_1200, 1, 0);
    run_op("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 0);
    run_op("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0);
    run_op("mul", ALU_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 33, 0);
    run_op("mulhu", ALU_MULHU, 32'hFFFF_FFFF, 32'd2, 32'd1, 33, 0);
    run_op("div", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
    run_op("rem", ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
    run_op("divu", ALU_DIVU, 32'd100, 32'd7, 32'd14, 33, 0);
    run_op("remu", ALU_REMU, 32'd100, 32'd7, 32'd2, 33, 0);
    run_op("divu0", ALU_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op("remu0", ALU_REMU, 32'd7, 32'd0, 32'd7, 1, 0);
    run_op("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
    run_op("div_bp", ALU_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, 5);

    // flush in the tenth busy cycle
    issue(ALU_MUL, 32'd3, 32'd4);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", W'(busy), W'(0));
    chk("flush_out_valid", W'(out_valid), W'(0));
    chk("flush_in_ready", W'(in_ready), W'(1));
    chk("flush_result_kept", result, 32'hFFFF_FFF2);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_output", W'(seen), W'(0));

    // flush wins over a same-cycle request
    @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1;
    alu_ctrl = ALU_ADD;
    a = 32'd1;
    b = 32'd1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_in_busy", W'(busy), W'(0));
    chk("flush_in_valid", W'(out_valid), W'(0));

    // reset in the middle of a divide
    issue(ALU_DIVU, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_result", result, '0);
    chk("mid_rst_zero", W'(zero), W'(0));
    chk("mid_rst_valid", W'(out_valid), W'(0));
    chk("mid_rst_busy", W'(busy), W'(0));
    chk("mid_rst_in_ready", W'(in_ready), W'(1));
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst_remu", ALU_REMU, 32'd100, 32'd7, 32'd2, 33, 0);
    run_op("post_rst_and", ALU_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1, 0);

    repeat (3) @(posedge clk);
    chk("queue_empty", W'(exp_q.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
